// File: rtl/spi_slave_uc_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_slave_uc_if : SPI pins plus fabric strobe/hold word handshake   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface spi_slave_uc_if #(
    parameter int outBits = 16
);
    logic               SCK;
    logic               CSbar;
    logic               MOSI;
    logic               MISO;
    logic               MISO_OE;
    logic [outBits-1:0] DATA_TX;
    logic               TX_ACK;
    logic [outBits-1:0] DATA_RX;
    logic               RX_VALID;
    logic               BUSY;
    logic               ERR;

    modport slave (
        input  SCK, CSbar, MOSI, DATA_TX,
        output MISO, MISO_OE, TX_ACK, DATA_RX, RX_VALID, BUSY, ERR
    );

    modport master (
        output SCK, CSbar, MOSI, DATA_TX,
        input  MISO, MISO_OE, TX_ACK, DATA_RX, RX_VALID, BUSY, ERR
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave_uc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_slave_uc : mode-0 MSB-first SPI slave, pins oversampled by clk  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module spi_slave_uc #(
    parameter int outBits     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic      SYS_CLK,
    input  wire logic      RST,
    spi_slave_uc_if.slave  spi
);

    localparam int                 CNT_W  = $clog2(outBits + 1);
    localparam logic [CNT_W-1:0]   c_LAST = CNT_W'(outBits - 1);
    localparam logic [CNT_W-1:0]   c_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_csb_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_flush;
    logic                   r_sck_hist;
    logic                   r_csb_hist;
    logic                   r_csb_armed;

    logic                   w_sck_s;
    logic                   w_csb_s;
    logic                   w_mosi_s;
    logic                   w_sck_rise;
    logic                   w_sck_fall;
    logic                   w_csb_fall;
    logic                   w_csb_rise;

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            r_sck_sync  <= '0;
            r_csb_sync  <= '1;
            r_mosi_sync <= '0;
            r_flush     <= '0;
            r_sck_hist  <= 1'b0;
            r_csb_hist  <= 1'b1;
            r_csb_armed <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi.SCK};
            r_csb_sync  <= {r_csb_sync[SYNC_STAGES-2:0], spi.CSbar};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
            r_flush     <= {r_flush[SYNC_STAGES-2:0], 1'b1};
            r_sck_hist  <= w_sck_s;
            r_csb_hist  <= w_csb_s;
            // Preset ones in the CSbar chain are not a real deselect; only
            // a high level sampled from the pin arms frame detection.
            if (r_flush[SYNC_STAGES-1] && w_csb_s)
                r_csb_armed <= 1'b1;
        end
    end

    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_csb_s    = r_csb_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise =  w_sck_s & ~r_sck_hist;
    assign w_sck_fall = ~w_sck_s &  r_sck_hist;
    assign w_csb_fall = ~w_csb_s &  r_csb_hist & r_csb_armed;
    assign w_csb_rise =  w_csb_s & ~r_csb_hist;

    state_t               r_state,    w_state_nxt;
    logic [CNT_W-1:0]     r_cnt,      w_cnt_nxt;
    logic [outBits-2:0]   r_rx_shift, w_rx_shift_nxt;
    logic [outBits-2:0]   r_tx_shift, w_tx_shift_nxt;
    logic [outBits-1:0]   r_data_rx,  w_data_rx_nxt;
    logic                 r_miso,     w_miso_nxt;
    logic                 r_miso_oe,  w_miso_oe_nxt;
    logic                 r_tx_ack,   w_tx_ack_nxt;
    logic                 r_rx_valid, w_rx_valid_nxt;
    logic                 r_err,      w_err_nxt;
    logic [outBits-1:0]   w_rx_word;

    // MISO itself carries the current MSB, so the tx/rx shifters hold one bit less.
    assign w_rx_word = {r_rx_shift, w_mosi_s};

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_data_rx  <= '0;
            r_miso     <= 1'b0;
            r_miso_oe  <= 1'b0;
            r_tx_ack   <= 1'b0;
            r_rx_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_data_rx  <= w_data_rx_nxt;
            r_miso     <= w_miso_nxt;
            r_miso_oe  <= w_miso_oe_nxt;
            r_tx_ack   <= w_tx_ack_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_rx_shift_nxt = r_rx_shift;
        w_tx_shift_nxt = r_tx_shift;
        w_data_rx_nxt  = r_data_rx;
        w_miso_nxt     = r_miso;
        w_miso_oe_nxt  = r_miso_oe;
        w_tx_ack_nxt   = 1'b0;
        w_rx_valid_nxt = 1'b0;
        w_err_nxt      = 1'b0;

        case (r_state)
            IDLE: begin
                w_miso_nxt    = 1'b0;
                w_miso_oe_nxt = 1'b0;
                if (w_csb_fall) begin
                    w_tx_shift_nxt = spi.DATA_TX[outBits-2:0];
                    w_miso_nxt     = spi.DATA_TX[outBits-1];
                    w_miso_oe_nxt  = 1'b1;
                    w_tx_ack_nxt   = 1'b1;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = ACTIVE;
                end
            end

            ACTIVE: begin
                // Deselect takes priority over any SCK edge in the same cycle.
                if (w_csb_rise) begin
                    w_err_nxt     = (r_cnt != c_ZERO);
                    w_miso_nxt    = 1'b0;
                    w_miso_oe_nxt = 1'b0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = IDLE;
                end else if (w_sck_rise) begin
                    w_rx_shift_nxt = w_rx_word[outBits-2:0];
                    w_cnt_nxt      = r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        w_data_rx_nxt  = w_rx_word;
                        w_rx_valid_nxt = 1'b1;
                        w_miso_nxt     = 1'b0;
                        w_state_nxt    = COMPLETE;
                    end
                end else if (w_sck_fall && (r_cnt != c_ZERO)) begin
                    w_miso_nxt     = r_tx_shift[outBits-2];
                    w_tx_shift_nxt = r_tx_shift << 1;
                end
            end

            COMPLETE: begin
                w_miso_nxt    = 1'b0;
                w_miso_oe_nxt = 1'b1;
                if (w_csb_rise) begin
                    w_miso_oe_nxt = 1'b0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = IDLE;
                end
            end

            default: begin
                w_miso_nxt    = 1'b0;
                w_miso_oe_nxt = 1'b0;
                w_cnt_nxt     = '0;
                w_state_nxt   = IDLE;
            end
        endcase
    end

    assign spi.MISO     = r_miso;
    assign spi.MISO_OE  = r_miso_oe;
    assign spi.TX_ACK   = r_tx_ack;
    assign spi.DATA_RX  = r_data_rx;
    assign spi.RX_VALID = r_rx_valid;
    assign spi.ERR      = r_err;
    assign spi.BUSY     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_uc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_spi_slave_uc : randomized frames checked against a word model    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_spi_slave_uc;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_slave_uc_if #(.outBits(W)) bus ();

    spi_slave_uc #(.outBits(W), .SYNC_STAGES(2)) dut (
        .SYS_CLK (clk),
        .RST     (rst),
        .spi     (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_ack = 0, n_rxv = 0, n_err = 0, n_overlap = 0;
    logic [W-1:0] m_rx = '0;

    always @(negedge clk) begin
        if (bus.TX_ACK)   n_ack++;
        if (bus.RX_VALID) n_rxv++;
        if (bus.ERR)      n_err++;
        if (int'(bus.TX_ACK) + int'(bus.RX_VALID) + int'(bus.ERR) > 1) n_overlap++;
    end

    // Reference: the first W bits clocked in form the word; MISO returns the
    // word captured at select, MSB first, then zeros.
    function automatic logic [W-1:0] exp_rx(input int n, input logic [31:0] v);
        return W'(v >> (n - W));
    endfunction

    function automatic logic [31:0] exp_miso(input logic [W-1:0] tx, input int n);
        logic [31:0] t;
        t = 32'(tx);
        return (n <= W) ? (t >> (W - n)) : (t << (n - W));
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [W-1:0] tx_start, input int nbits, input logic [31:0] mosi_vec,
                         input bit chg, input logic [W-1:0] tx_new,
                         output logic [31:0] miso_vec, output logic busy_mid);
        bus.DATA_TX = tx_start;
        miso_vec    = '0;
        busy_mid    = 1'b0;
        bus.CSbar   = 1'b0;
        cyc(6);
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI = mosi_vec[nbits-1-i];
            cyc(4);
            bus.SCK  = 1'b1;
            miso_vec = {miso_vec[30:0], bus.MISO};
            if (i == 0) busy_mid = bus.BUSY;
            if (chg && i == 2) bus.DATA_TX = tx_new;
            cyc(4);
            bus.SCK = 1'b0;
        end
        cyc(4);
        bus.CSbar = 1'b1;
        cyc(8);
    endtask

    task automatic toggle_sck(input int n);
        for (int i = 0; i < n; i++) begin
            bus.MOSI = 1'($urandom);
            bus.SCK  = 1'b1;
            cyc(4);
            bus.SCK  = 1'b0;
            cyc(4);
        end
    endtask

    task automatic test_reset;
        int a0, r0;
        bus.SCK = 1'b0; bus.CSbar = 1'b0; bus.MOSI = 1'b0; bus.DATA_TX = 16'hFFFF;
        rst = 1'b1;
        cyc(3);
        total++;
        if ({bus.MISO, bus.MISO_OE, bus.TX_ACK, bus.RX_VALID, bus.BUSY, bus.ERR, bus.DATA_RX} !== '0) begin
            bad++; $display("FAIL reset_outputs: got MISO=%b OE=%b DATA_RX=%h, expected all zero", bus.MISO, bus.MISO_OE, bus.DATA_RX);
        end
        rst = 1'b0;
        a0 = n_ack; r0 = n_rxv;
        cyc(4);
        toggle_sck(16);
        total++;
        if ((n_ack - a0) !== 0 || (n_rxv - r0) !== 0) begin
            bad++; $display("FAIL reset_low_cs_quiet: got ack=%0d rxv=%0d, expected 0 0", n_ack - a0, n_rxv - r0);
        end
        total++;
        if (bus.MISO_OE !== 1'b0 || bus.DATA_RX !== '0 || bus.BUSY !== 1'b0) begin
            bad++; $display("FAIL reset_low_cs_idle: got OE=%b DATA_RX=%h BUSY=%b, expected 0 0000 0", bus.MISO_OE, bus.DATA_RX, bus.BUSY);
        end
        bus.CSbar = 1'b1;
        cyc(8);
    endtask

    task automatic test_basic;
        int a0, r0, e0;
        logic [31:0] mv; logic bm;
        a0 = n_ack; r0 = n_rxv; e0 = n_err;
        frame(16'hA5C3, 16, 32'h1234, 1'b0, '0, mv, bm);
        m_rx = 16'h1234;
        total++;
        if ((n_ack - a0) !== 1) begin bad++; $display("FAIL basic_tx_ack: got %0d, expected 1", n_ack - a0); end
        total++;
        if (mv !== exp_miso(16'hA5C3, 16)) begin bad++; $display("FAIL basic_miso: got %h, expected %h", mv, exp_miso(16'hA5C3, 16)); end
        total++;
        if ((n_rxv - r0) !== 1 || (n_err - e0) !== 0) begin
            bad++; $display("FAIL basic_pulses: got rxv=%0d err=%0d, expected 1 0", n_rxv - r0, n_err - e0);
        end
        total++;
        if (bus.DATA_RX !== m_rx) begin bad++; $display("FAIL basic_data_rx: got %h, expected %h", bus.DATA_RX, m_rx); end
        total++;
        if (bm !== 1'b1 || bus.BUSY !== 1'b0) begin
            bad++; $display("FAIL basic_busy: got mid=%b after=%b, expected 1 0", bm, bus.BUSY);
        end
    endtask

    task automatic test_abort;
        int r0, e0;
        logic [31:0] mv; logic bm;
        r0 = n_rxv; e0 = n_err;
        frame(16'($urandom), 7, 32'($urandom), 1'b0, '0, mv, bm);
        total++;
        if ((n_err - e0) !== 1 || (n_rxv - r0) !== 0) begin
            bad++; $display("FAIL abort_pulses: got err=%0d rxv=%0d, expected 1 0", n_err - e0, n_rxv - r0);
        end
        total++;
        if (bus.DATA_RX !== m_rx) begin bad++; $display("FAIL abort_data_rx: got %h, expected %h", bus.DATA_RX, m_rx); end
        total++;
        if (bus.BUSY !== 1'b0 || bus.MISO_OE !== 1'b0) begin
            bad++; $display("FAIL abort_idle: got BUSY=%b OE=%b, expected 0 0", bus.BUSY, bus.MISO_OE);
        end
    endtask

    task automatic test_overrun;
        int r0;
        logic [31:0] mv; logic bm; logic [W-1:0] tx;
        tx = 16'($urandom) | 16'h0001;
        r0 = n_rxv;
        frame(tx, 20, {12'h0, 16'hFFFF, 4'h0}, 1'b0, '0, mv, bm);
        m_rx = exp_rx(20, {12'h0, 16'hFFFF, 4'h0});
        total++;
        if (bus.DATA_RX !== m_rx || (n_rxv - r0) !== 1) begin
            bad++; $display("FAIL overrun_rx: got %h rxv=%0d, expected %h 1", bus.DATA_RX, n_rxv - r0, m_rx);
        end
        total++;
        if (mv !== exp_miso(tx, 20)) begin bad++; $display("FAIL overrun_miso: got %h, expected %h", mv, exp_miso(tx, 20)); end
    endtask

    task automatic test_tx_hold;
        logic [31:0] mv; logic bm; logic [31:0] v;
        v = 32'($urandom);
        frame(16'hA5C3, 16, v, 1'b1, 16'h0F0F, mv, bm);
        m_rx = exp_rx(16, v);
        total++;
        if (mv !== exp_miso(16'hA5C3, 16)) begin bad++; $display("FAIL txhold_same_frame: got %h, expected %h", mv, exp_miso(16'hA5C3, 16)); end
        frame(16'h0F0F, 16, v, 1'b0, '0, mv, bm);
        total++;
        if (mv !== exp_miso(16'h0F0F, 16)) begin bad++; $display("FAIL txhold_next_frame: got %h, expected %h", mv, exp_miso(16'h0F0F, 16)); end
    endtask

    task automatic test_reset_mid;
        int a0, r0, e0;
        logic [31:0] mv; logic bm; logic [W-1:0] tx;
        bus.DATA_TX = 16'($urandom);
        bus.CSbar   = 1'b0;
        cyc(6);
        toggle_sck(9);
        rst = 1'b1;
        #1;
        total++;
        if ({bus.MISO, bus.MISO_OE, bus.TX_ACK, bus.RX_VALID, bus.BUSY, bus.ERR, bus.DATA_RX} !== '0) begin
            bad++; $display("FAIL rstmid_outputs: got OE=%b BUSY=%b DATA_RX=%h, expected all zero", bus.MISO_OE, bus.BUSY, bus.DATA_RX);
        end
        m_rx = '0;
        cyc(3);
        rst = 1'b0;
        a0 = n_ack; r0 = n_rxv; e0 = n_err;
        cyc(4);
        toggle_sck(16);
        total++;
        if ((n_ack - a0) !== 0 || (n_rxv - r0) !== 0 || (n_err - e0) !== 0 || bus.MISO_OE !== 1'b0) begin
            bad++; $display("FAIL rstmid_quiet: got ack=%0d rxv=%0d err=%0d OE=%b, expected 0 0 0 0", n_ack - a0, n_rxv - r0, n_err - e0, bus.MISO_OE);
        end
        bus.CSbar = 1'b1;
        cyc(8);
        tx = 16'($urandom);
        a0 = n_ack;
        frame(tx, 16, 32'hBEEF, 1'b0, '0, mv, bm);
        m_rx = 16'hBEEF;
        total++;
        if (bus.DATA_RX !== m_rx || mv !== exp_miso(tx, 16) || (n_ack - a0) !== 1) begin
            bad++; $display("FAIL rstmid_clean_frame: got rx=%h miso=%h ack=%0d, expected %h %h 1", bus.DATA_RX, mv, n_ack - a0, m_rx, exp_miso(tx, 16));
        end
    endtask

    task automatic test_random;
        int a0, r0, e0, n, sel;
        logic [31:0] mv, v; logic bm; logic [W-1:0] tx;
        for (int k = 0; k < 8; k++) begin
            sel = int'($urandom_range(0, 2));
            n   = (sel == 0) ? W : (sel == 1) ? int'($urandom_range(1, W - 1)) : int'($urandom_range(W + 1, 20));
            tx  = 16'($urandom);
            v   = 32'($urandom);
            a0 = n_ack; r0 = n_rxv; e0 = n_err;
            frame(tx, n, v, 1'b0, '0, mv, bm);
            if (n >= W) m_rx = exp_rx(n, v);
            total++;
            if (mv !== exp_miso(tx, n) || (n_ack - a0) !== 1) begin
                bad++; $display("FAIL rand_tx n=%0d: got miso=%h ack=%0d, expected %h 1", n, mv, n_ack - a0, exp_miso(tx, n));
            end
            total++;
            if (bus.DATA_RX !== m_rx || (n_rxv - r0) !== ((n >= W) ? 1 : 0) || (n_err - e0) !== ((n >= W) ? 0 : 1)) begin
                bad++; $display("FAIL rand_rx n=%0d: got rx=%h rxv=%0d err=%0d, expected %h", n, bus.DATA_RX, n_rxv - r0, n_err - e0, m_rx);
            end
        end
        total++;
        if (n_overlap !== 0) begin bad++; $display("FAIL pulse_overlap: got %0d cycles, expected 0", n_overlap); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_abort;
        test_overrun;
        test_tx_hold;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_uc.md
Name: spi_slave_uc

Overview:
SPI slave (mode 0, MSB first) that sits at the far end of the microcontroller SPI link. It receives one outBits-wide word on MOSI per CSbar-low frame and returns one word on MISO in the same frame. All SPI pins are asynchronous to SYS_CLK: they are synchronised, edge-detected and processed by a small FSM in the SYS_CLK domain. Words are delivered to and taken from the fabric over strobe/hold handshakes.

Parameters:
outBits, 16, word length in bits (2..32)
SYNC_STAGES, 2, flip-flop stages on SCK/CSbar/MOSI (minimum 2)

Ports:
SYS_CLK  input  1  system clock; the only clock in the block
RST  input  1  asynchronous, active-high reset
SCK  input  1  SPI clock from master (asynchronous)
CSbar  input  1  active-low chip select from master (asynchronous)
MOSI  input  1  serial data from master
MISO  output  1  serial data to master
MISO_OE  output  1  pad output-enable for MISO; high only while selected
DATA_TX  input  outBits  word to return; sampled once per frame
TX_ACK  output  1  one-cycle pulse: DATA_TX has just been sampled
DATA_RX  output  outBits  last complete received word; held until the next complete word
RX_VALID  output  1  one-cycle pulse: DATA_RX has just been updated
BUSY  output  1  high while in ACTIVE or COMPLETE
ERR  output  1  one-cycle pulse: frame aborted before outBits bits were received

Behaviour:
- Reset (asynchronous): all outputs 0, FSM=IDLE, bit counter 0, shift registers 0. CSbar synchroniser chain presets to 1; SCK chain clears to 0. Consequence: CSbar already low at reset release is not a falling edge; the block waits for CSbar to go high, then low again.
- Synchronisation: each pin passes through SYNC_STAGES flops plus one history flop. Edge events (SCK rise/fall, CSbar fall/rise) are single-cycle strobes, SYNC_STAGES+1 SYS_CLK cycles after the pin edge.
- Timing requirement on the master: SCK high and low phases each >= 4 SYS_CLK periods; CSbar fall to first SCK rise >= 4 SYS_CLK periods; CSbar rise to next fall >= 4 SYS_CLK periods.
- FSM IDLE: MISO_OE=0, MISO=0, BUSY=0. On CSbar fall: load tx_shift<=DATA_TX, pulse TX_ACK, MISO<=DATA_TX[outBits-1], MISO_OE<=1, counter<=0, go to ACTIVE.
- FSM ACTIVE, SCK rise: rx_shift<={rx_shift[outBits-2:0], MOSI_sync}; counter+1. When the counter reaches outBits: DATA_RX<=completed word (no shift or offset), RX_VALID pulse in the same cycle DATA_RX updates, go to COMPLETE.
- FSM ACTIVE, SCK fall: tx_shift shifts left with 0 fill; MISO<=new MSB. A fall before the first rise (counter=0) is ignored.
- FSM COMPLETE: MISO=0, MISO_OE=1. Further SCK edges are ignored, with no wrap into a second word. CSbar rise goes to IDLE.
- CSbar rise in ACTIVE: if counter=0, return to IDLE silently. If 1..outBits-1, pulse ERR, discard the partial word (DATA_RX unchanged, no RX_VALID), go to IDLE.
- Simultaneous SCK edge and CSbar rise in one cycle: CSbar rise wins and the SCK edge is dropped.
- Simultaneous CSbar fall and SCK edge: the SCK edge is dropped.
- DATA_TX is sampled only at the CSbar-fall cycle; later changes do not affect the current frame.
- RX_VALID, TX_ACK and ERR are never asserted in the same cycle as each other, except TX_ACK with nothing else.

Test Plan:
- Reset with CSbar low, release, keep CSbar low and toggle SCK 16x -> no TX_ACK, no RX_VALID, MISO_OE=0, DATA_RX=0.
- outBits=16, DATA_TX=16'hA5C3, master sends 16'h1234 at SCK=SYS_CLK/8 -> TX_ACK once at frame start; MISO bits sampled on SCK rises = A5C3 MSB first; RX_VALID once; DATA_RX=16'h1234; BUSY low after CSbar rise.
- Abort after 7 SCK rises (CSbar high) -> ERR pulse, DATA_RX keeps its previous value (16'h1234), no RX_VALID, FSM back in IDLE.
- 20 SCK pulses in one frame with MOSI=16'hFFFF then 4 zeros -> DATA_RX=16'hFFFF, single RX_VALID, MISO=0 for pulses 17..20.
- Change DATA_TX to 16'h0F0F mid-frame after TX_ACK -> master still receives 16'hA5C3; next frame returns 16'h0F0F.
- Assert RST at bit 9 of a frame -> outputs 0 immediately; after release with CSbar still low, no activity until CSbar high then low, after which a clean 16'hBEEF frame is received correctly.
